lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Ports SHALL be as follows; clock and reset are first.
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores.
- resp_err  out  1  request rejected; valid with resp_valid.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  32  word-aligned address (low 2 bits SHALL be 00).
- mem_wdata  out  32  full-word write data.
- mem_rdata  in  32  combinational read data from data memory.
REQ-002 The design SHALL use one clock; reset is synchronous and active-low, with clk and rst_n as above.

Function
REQ-003 The FSM states SHALL be IDLE, RD0, RD1, WR0, WR1, RESP. req_ready SHALL be 1 only in IDLE, and a handshake occurs when req_valid and req_ready are both 1.
REQ-004 On handshake, the block SHALL latch we, size, unsigned, addr and wdata. It SHALL compute off = addr[1:0] and nb = 1/2/4, and set span = (off + nb > 4).
REQ-005 The word addresses SHALL be w0 = {addr[31:2],2'b00} and w1 = w0 + 4, computed modulo 2^32 so that 0xFFFFFFFC wraps to 0x00000000.
REQ-006 Sequencing by request type:
- Load, no span: RD0 -> RESP.
- Load, span: RD0 -> RD1 -> RESP.
- Word store, off = 0: WR0 -> RESP.
- Other store, no span: RD0 -> WR0 -> RESP.
- Store, span: RD0 -> RD1 -> WR0 -> WR1 -> RESP.
- RESP -> IDLE unconditionally.
REQ-007 In RD0 and RD1, mem_read SHALL be 1 and mem_addr SHALL be w0 or w1 respectively. mem_rdata SHALL be captured into the word0 or word1 register on the clock edge ending that state.
REQ-008 In WR0 and WR1, mem_write SHALL be 1 and mem_addr SHALL be w0 or w1 respectively. mem_wdata SHALL be the captured word with only the addressed byte lanes replaced by store bytes, least-significant store byte at lane off, continuing into word1 lanes 0.. when the access spans.
REQ-009 Load result: the nb bytes starting at byte off of {word1, word0} SHALL be sign-extended, or zero-extended when unsigned. Word loads SHALL ignore req_unsigned.
REQ-010 resp_valid SHALL be 1 only in RESP, and resp_rdata SHALL be held stable through RESP.
REQ-011 req_size = 11 SHALL skip all memory states: IDLE -> RESP with resp_err = 1, resp_rdata = 0, and no mem_read or mem_write.
REQ-012 mem_read and mem_write SHALL never both be 1 in the same cycle, and both SHALL be 0 in IDLE and RESP.
REQ-013 req_valid outside IDLE SHALL be ignored, and the request SHALL NOT be queued.

Reset
REQ-014 With rst_n = 0 at a rising edge, the next state SHALL be IDLE, all capture registers SHALL be 0, resp_valid, resp_err and resp_rdata SHALL be 0, and req_ready SHALL be 1 after that edge.
REQ-015 mem_read and mem_write SHALL be gated by rst_n, so that no memory write occurs on the edge where reset is sampled, even when reset is asserted mid-WR0 or mid-WR1.

Configuration
REQ-016 The macro LSU_MISALIGN_EN SHALL select misaligned handling:
- Defined: misaligned accesses (addr not a multiple of nb) SHALL be handled per REQ-006, including span splitting.
- Undefined: any misaligned request SHALL go IDLE -> RESP with resp_err = 1 and no memory access, and the RD1 and WR1 states SHALL be absent.

Structure
REQ-017 A package lsu_pkg SHALL hold:
- the size encodings;
- the FSM state enum;
- a size-to-nb function;
- a constant for the word alignment mask.
REQ-018 A single combinational sub-module, lsu_lane_align, SHALL perform byte-lane extraction with sign extension and lane merge for stores. The FSM, registers and memory drive SHALL live in lsu_mem_stage.

Verification
REQ-019 Word load at 0x10 with mem holding 0x11223344: resp_valid SHALL occur 2 cycles after the handshake, resp_rdata = 0x11223344, and there SHALL be one mem_read to 0x10.
REQ-020 Signed byte load at 0x13 over word 0x80FF0000: resp_rdata SHALL be 0xFFFFFF80; with req_unsigned = 1 it SHALL be 0x00000080.
REQ-021 Half store 0xBEEF to 0x22 over word 0x12345678 at 0x20: there SHALL be a read of 0x20, then a write of 0x20 with data 0xBEEF5678, and resp_err = 0.
REQ-022 With LSU_MISALIGN_EN defined, word store 0xAABBCCDD to 0x103 over zeros: writes SHALL be 0x100 <- 0xDD000000 and 0x104 <- 0x00AABBCC, and resp_valid SHALL occur 5 cycles after the handshake. With the macro undefined: resp_err = 1 and no memory access.
REQ-023 Reset asserted during WR0: mem_write SHALL be 0 on that edge, the state SHALL be IDLE on the next cycle, and memory SHALL be unchanged.
REQ-024 req_size = 11: resp_err = 1 SHALL occur one cycle after the handshake with no memory activity, and a req_valid held high during RESP SHALL be ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU memory stage.
//   - access size encodings carried on req_size
//   - FSM state enum (RD1/WR1 exist only when LSU_MISALIGN_EN is defined)
//   - size_nb(): access size to byte count
//   - WORD_ALIGN_MASK: clears the byte offset of an address
// Build option: LSU_MISALIGN_EN enables misaligned and word-spanning accesses.
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD0, WR0, RESP} state_t;
`endif

  function automatic logic [2:0] size_nb(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic for the LSU.
//   word0, word1 : captured memory words (word1 follows word0 in memory)
//   off          : byte offset of the access within word0
//   size         : access size encoding
//   is_unsigned  : zero-extend sub-word loads
//   wdata        : right-justified store data
//   hi           : select the word1 half of the merged store pair
//   load_data    : extracted and extended load result
//   merge_word   : selected word with addressed lanes replaced by store bytes
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic        hi,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [63:0] pair;
  logic [5:0]  sh;
  logic [31:0] shifted;
  logic [63:0] mask;
  logic [63:0] data;
  logic [63:0] merged;

  always_comb begin
    pair    = {word1, word0};
    sh      = {1'b0, off, 3'b000};
    shifted = 32'(pair >> sh);

    case (size)
      SIZE_B:  load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase

    case (size)
      SIZE_B:  mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
    mask   = mask << sh;
    data   = {32'h0, wdata} << sh;
    merged = (pair & ~mask) | (data & mask);

    merge_word = hi ? merged[63:32] : merged[31:0];
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit memory stage. Accepts one core request at a
// time, performs read-modify-write sequencing against a word-wide data memory
// and returns a one-cycle response.
//   clk, rst_n    : clock, synchronous active-low reset
//   req_*         : core request (valid/ready handshake, we, size, unsigned,
//                   addr, wdata)
//   resp_*        : completion pulse, extended load data, error flag
//   mem_*         : data memory read/write strobes, word address, data
// Build option: LSU_MISALIGN_EN enables misaligned accesses, including the
// two-word split (RD1/WR1); without it misaligned requests return an error.
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word0;
  logic [31:0] w0;
  logic [31:0] word0_in;
  logic [31:0] word1_in;
  logic [31:0] load_data;
  logic        hi;
  logic        err_in;

  assign w0 = addr_q & WORD_ALIGN_MASK;

`ifdef LSU_MISALIGN_EN
  logic        span_q;
  logic        span_in;
  logic [3:0]  end_in;
  logic [31:0] word1;
  logic [31:0] w1;

  assign w1       = w0 + 32'd4;
  assign end_in   = {2'b00, req_addr[1:0]} + {1'b0, size_nb(req_size)};
  assign span_in  = end_in > 4'd4;
  assign err_in   = (req_size == SIZE_RSV);
  assign mem_addr = (state == RD1 || state == WR1) ? w1 : w0;
  assign word1_in = (state == RD1) ? mem_rdata : word1;
  assign hi       = (state == WR1);
  assign mem_read  = rst_n && (state == RD0 || state == RD1);
  assign mem_write = rst_n && (state == WR0 || state == WR1);
`else
  logic misaligned;

  assign misaligned = (req_size == SIZE_H && req_addr[0]) ||
                      (req_size == SIZE_W && req_addr[1:0] != 2'b00);
  assign err_in   = (req_size == SIZE_RSV) || misaligned;
  assign mem_addr = w0;
  assign word1_in = '0;
  assign hi       = 1'b0;
  assign mem_read  = rst_n && (state == RD0);
  assign mem_write = rst_n && (state == WR0);
`endif

  assign req_ready = (state == IDLE);

  // Bypass the read data so the load result can be registered on the same
  // edge that captures the final word.
  assign word0_in = (state == RD0) ? mem_rdata : word0;

  lsu_lane_align u_align (
    .word0       (word0_in),
    .word1       (word1_in),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .hi          (hi),
    .load_data   (load_data),
    .merge_word  (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word0      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
`ifdef LSU_MISALIGN_EN
      span_q     <= 1'b0;
      word1      <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EN
            span_q  <= span_in;
`endif
            if (err_in) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_size == SIZE_W && req_addr[1:0] == 2'b00) begin
              state <= WR0;
            end else begin
              state <= RD0;
            end
          end
        end
        RD0: begin
          word0 <= mem_rdata;
`ifdef LSU_MISALIGN_EN
          if (span_q) begin
            state <= RD1;
          end else
`endif
          if (we_q) begin
            state <= WR0;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
`ifdef LSU_MISALIGN_EN
        RD1: begin
          word1 <= mem_rdata;
          if (we_q) begin
            state <= WR0;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
`endif
        WR0: begin
`ifdef LSU_MISALIGN_EN
          if (span_q) begin
            state <= WR1;
          end else
`endif
          begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] mem [0:127];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          viol   = 0;
  logic [31:0] rd_log [0:63];
  logic [31:0] wa_log [0:63];
  logic [31:0] wd_log [0:63];

  lsu_mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-word memory; 0xFFFFFFFC aliases to index 127, which no test uses otherwise.
  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_read && mem_write) viol++;
    if ((mem_read || mem_write) && mem_addr[1:0] != 2'b00) viol++;
    if (req_ready && (mem_read || mem_write || resp_valid)) viol++;
    if (mem_read) begin
      rd_log[rd_cnt % 64] = mem_addr;
      rd_cnt++;
    end
    if (mem_write) begin
      mem[mem_addr[8:2]] <= mem_wdata;
      wa_log[wr_cnt % 64] = mem_addr;
      wd_log[wr_cnt % 64] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic err);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd  = resp_rdata;
    err = resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass_cnt++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
    total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b exp 0", resp_err); else pass_cnt++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", resp_rdata); else pass_cnt++;
    total++; if ((mem_read | mem_write) !== 1'b0) $display("FAIL rst_mem got %b%b exp 00", mem_read, mem_write); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    int lat;
    logic [31:0] rd;
    logic err;
    int r0;
    int w0;
    mem[4] = 32'h1122_3344;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err);
    total++; if (lat !== 2) $display("FAIL wload_lat got %0d exp 2", lat); else pass_cnt++;
    total++; if (rd !== 32'h1122_3344) $display("FAIL wload_data got %h exp 11223344", rd); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL wload_err got %b exp 0", err); else pass_cnt++;
    total++; if (rd_cnt - r0 !== 1) $display("FAIL wload_nreads got %0d exp 1", rd_cnt - r0); else pass_cnt++;
    total++; if (rd_log[r0 % 64] !== 32'h10) $display("FAIL wload_raddr got %h exp 00000010", rd_log[r0 % 64]); else pass_cnt++;
    total++; if (wr_cnt - w0 !== 0) $display("FAIL wload_nwrites got %0d exp 0", wr_cnt - w0); else pass_cnt++;

    mem[4] = 32'h80FF_0000;
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, err);
    total++; if (rd !== 32'hFFFF_FF80) $display("FAIL sbyte_data got %h exp ffffff80", rd); else pass_cnt++;
    total++; if (lat !== 2) $display("FAIL sbyte_lat got %0d exp 2", lat); else pass_cnt++;
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, err);
    total++; if (rd !== 32'h0000_0080) $display("FAIL ubyte_data got %h exp 00000080", rd); else pass_cnt++;
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, err);
    total++; if (rd !== 32'hFFFF_80FF) $display("FAIL shalf_data got %h exp ffff80ff", rd); else pass_cnt++;
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, err);
    total++; if (rd !== 32'h80FF_0000) $display("FAIL uword_data got %h exp 80ff0000", rd); else pass_cnt++;
  endtask

  task automatic test_stores();
    int lat;
    logic [31:0] rd;
    logic err;
    int r0;
    int w0;
    mem[8] = 32'h1234_5678;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, rd, err);
    total++; if (lat !== 3) $display("FAIL hstore_lat got %0d exp 3", lat); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL hstore_err got %b exp 0", err); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL hstore_rdata got %h exp 0", rd); else pass_cnt++;
    total++; if (rd_cnt - r0 !== 1 || rd_log[r0 % 64] !== 32'h20) $display("FAIL hstore_read got n=%0d a=%h exp n=1 a=00000020", rd_cnt - r0, rd_log[r0 % 64]); else pass_cnt++;
    total++; if (wr_cnt - w0 !== 1 || wa_log[w0 % 64] !== 32'h20) $display("FAIL hstore_waddr got n=%0d a=%h exp n=1 a=00000020", wr_cnt - w0, wa_log[w0 % 64]); else pass_cnt++;
    total++; if (wd_log[w0 % 64] !== 32'hBEEF_5678) $display("FAIL hstore_wdata got %h exp beef5678", wd_log[w0 % 64]); else pass_cnt++;

    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFA5, lat, rd, err);
    total++; if (mem[8] !== 32'hBEEF_A578) $display("FAIL bstore_mem got %h exp beefa578", mem[8]); else pass_cnt++;

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_BABE, lat, rd, err);
    total++; if (lat !== 2) $display("FAIL wstore_lat got %0d exp 2", lat); else pass_cnt++;
    total++; if (rd_cnt - r0 !== 0) $display("FAIL wstore_nreads got %0d exp 0", rd_cnt - r0); else pass_cnt++;
    total++; if (mem[12] !== 32'hCAFE_BABE) $display("FAIL wstore_mem got %h exp cafebabe", mem[12]); else pass_cnt++;
  endtask

  task automatic test_misalign();
    int lat;
    logic [31:0] rd;
    logic err;
    int r0;
    int w0;
    mem[64]  = 32'h0;
    mem[65]  = 32'h0;
    mem[127] = 32'h4433_2211;
    mem[0]   = 32'h8877_6655;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h103, 32'hAABB_CCDD, lat, rd, err);
`ifdef LSU_MISALIGN_EN
    total++; if (lat !== 5) $display("FAIL mstore_lat got %0d exp 5", lat); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL mstore_err got %b exp 0", err); else pass_cnt++;
    total++; if (wr_cnt - w0 !== 2) $display("FAIL mstore_nwrites got %0d exp 2", wr_cnt - w0); else pass_cnt++;
    total++; if (wa_log[w0 % 64] !== 32'h100 || wd_log[w0 % 64] !== 32'hDD00_0000) $display("FAIL mstore_w0 got %h<-%h exp 00000100<-dd000000", wa_log[w0 % 64], wd_log[w0 % 64]); else pass_cnt++;
    total++; if (wa_log[(w0 + 1) % 64] !== 32'h104 || wd_log[(w0 + 1) % 64] !== 32'h00AA_BBCC) $display("FAIL mstore_w1 got %h<-%h exp 00000104<-00aabbcc", wa_log[(w0 + 1) % 64], wd_log[(w0 + 1) % 64]); else pass_cnt++;
    r0 = rd_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFD, 32'h0, lat, rd, err);
    total++; if (lat !== 3) $display("FAIL wrap_lat got %0d exp 3", lat); else pass_cnt++;
    total++; if (rd !== 32'h5544_3322) $display("FAIL wrap_data got %h exp 55443322", rd); else pass_cnt++;
    total++; if (rd_log[r0 % 64] !== 32'hFFFF_FFFC || rd_log[(r0 + 1) % 64] !== 32'h0) $display("FAIL wrap_raddr got %h,%h exp fffffffc,00000000", rd_log[r0 % 64], rd_log[(r0 + 1) % 64]); else pass_cnt++;
`else
    total++; if (lat !== 1) $display("FAIL mstore_lat got %0d exp 1", lat); else pass_cnt++;
    total++; if (err !== 1'b1) $display("FAIL mstore_err got %b exp 1", err); else pass_cnt++;
    total++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) $display("FAIL mstore_mem got r=%0d w=%0d exp r=0 w=0", rd_cnt - r0, wr_cnt - w0); else pass_cnt++;
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, err);
    total++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL mhalf_err got err=%b rd=%h exp err=1 rd=0", err, rd); else pass_cnt++;
    total++; if (rd_cnt - r0 !== 0) $display("FAIL mhalf_nreads got %0d exp 0", rd_cnt - r0); else pass_cnt++;
`endif
  endtask

  task automatic test_reserved();
    int r0;
    int w0;
    int seen;
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) $display("FAIL rsv_resp got v=%b e=%b exp v=1 e=1", resp_valid, resp_err); else pass_cnt++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL rsv_rdata got %h exp 0", resp_rdata); else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b1) $display("FAIL rsv_idle got %b exp 1", req_ready); else pass_cnt++;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL rsv_ignored got %0d extra responses exp 0", seen); else pass_cnt++;
    total++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) $display("FAIL rsv_mem got r=%0d w=%0d exp r=0 w=0", rd_cnt - r0, wr_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    int w0;
    mem[16] = 32'h5555_AAAA;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h1234_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++; if (mem_write !== 1'b1) $display("FAIL mid_wr0 got %b exp 1", mem_write); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (mem_write !== 1'b0) $display("FAIL mid_gate got %b exp 0", mem_write); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL mid_idle got rdy=%b v=%b exp rdy=1 v=0", req_ready, resp_valid); else pass_cnt++;
    total++; if (mem[16] !== 32'h5555_AAAA || wr_cnt - w0 !== 0) $display("FAIL mid_mem got %h n=%0d exp 5555aaaa n=0", mem[16], wr_cnt - w0); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_invariants();
    total++; if (viol !== 0) $display("FAIL mem_invariants got %0d violations exp 0", viol); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_reserved();
    test_reset_mid_write();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
